// File: rtl/spi_tx_feeder_pkg.sv
// Shared definitions for the SPI transmit feeder: sequencer states, frame size
// and the handshake levels the downstream sender presents.
package spi_tx_feeder_pkg;

    localparam int SPI_FRAME_BITS = 8;

    // Level of the sender's EMPTY_STATE once the last bit has left the shifter.
    localparam logic SENDER_EMPTY_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Host-side queue signals and sender-side drive signals of the SPI transmit feeder.
interface spi_tx_feeder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] DIN;
    logic             PUSH;
    logic             START;
    logic             READY;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S_DATA;
    logic             S_WRITE;
    logic             S_TE;
    logic             S_EMPTY;

    modport slave (
        input  DIN, PUSH, START, S_EMPTY,
        output READY, COUNT, OVERFLOW, BUSY, DONE, S_DATA, S_WRITE, S_TE
    );

    modport master (
        output DIN, PUSH, START, S_EMPTY,
        input  READY, COUNT, OVERFLOW, BUSY, DONE, S_DATA, S_WRITE, S_TE
    );

endinterface

// File: rtl/spi_tx_feeder_byte_fifo.sv
// Small power-of-two byte FIFO with a combinationally visible head entry.
// Fullness and emptiness are judged on the count before this edge's push/pop.
module spi_tx_feeder_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte queue plus burst sequencer driving the SPI sender's DATA/WRITE/TE inputs,
// one byte every 10 cycles, with a single-cycle DONE when the queue is drained.
module spi_tx_feeder
    import spi_tx_feeder_pkg::*;
#(
    parameter int WIDTH = SPI_FRAME_BITS,
    parameter int DEPTH = 4
) (
    input  logic           CLK,
    input  logic           CLR,
    spi_tx_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WIDTH) + 1;

    state_t           state_r;
    state_t           state_next_s;
    logic [BW-1:0]    bit_cnt_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;
    logic             s_write_r;
    logic             s_te_r;
    logic [WIDTH-1:0] head_s;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;

    assign pop_s = (state_r == ST_LOAD);

    spi_tx_feeder_byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .clr   (CLR),
        .push  (bus.PUSH),
        .pop   (pop_s),
        .din   (bus.DIN),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state decode; START is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    if (!empty_s) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_FINISH;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_r == BW'(WIDTH - 1)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                if (bus.S_EMPTY == SENDER_EMPTY_LEVEL) begin
                    if (!empty_s) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_FINISH;
                    end
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bit counter: zeroed while loading, counts shift edges.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            bit_cnt_r <= {BW{1'b0}};
        end else if (state_r == ST_LOAD) begin
            bit_cnt_r <= {BW{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Sticky overflow: a push that found the FIFO full was dropped.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            overflow_r <= 1'b0;
        end else if (bus.PUSH && full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Control outputs registered from the next state, so they equal a
    // glitch-free Moore decode of the state register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            s_write_r <= 1'b0;
            s_te_r    <= 1'b0;
        end else begin
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= (state_next_s == ST_FINISH);
            s_write_r <= (state_next_s == ST_LOAD);
            s_te_r    <= (state_next_s == ST_SHIFT);
        end
    end

    assign bus.READY    = ~full_s;
    assign bus.COUNT    = count_s;
    assign bus.OVERFLOW = overflow_r;
    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;
    assign bus.S_DATA   = head_s;
    assign bus.S_WRITE  = s_write_r;
    assign bus.S_TE     = s_te_r;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Bench for spi_tx_feeder: behavioural sender/receiver loop plus a burst-phase
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_spi_tx_feeder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic stall = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    spi_tx_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    spi_tx_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sender: loads on WRITE, shifts MSB first while TE, empty after 8 bits.
    logic [7:0] snd_sh = 8'h00;
    int         snd_left = 0;
    always @(posedge clk) begin
        if (clr) begin
            snd_sh   <= 8'h00;
            snd_left <= 0;
        end else if (bus.S_WRITE) begin
            snd_sh   <= bus.S_DATA;
            snd_left <= 8;
        end else if (bus.S_TE && snd_left > 0) begin
            snd_sh   <= snd_sh << 1;
            snd_left <= snd_left - 1;
        end
    end
    assign bus.S_EMPTY = (snd_left == 0) && !stall;

    // Reference model state: FIFO contents, burst phase within a byte period.
    logic [7:0] q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_n = 0;
    bit         m_valid = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_act = 1'b0;
    bit         m_fin = 1'b0;
    int         m_ph = 0;   // 0 = load, 1..8 = shifting, 9 = draining

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz;
        bit acc;
        sz = q.size();
        cyc++;
        if (clr) begin
            q.delete();
            m_ovf = 1'b0; m_act = 1'b0; m_fin = 1'b0; m_ph = 0;
            rx_n = 0; m_valid = 1'b1;
        end else begin
            if (bus.S_TE && snd_left > 0) begin
                rx_sh = {rx_sh[6:0], snd_sh[7]};
                rx_n++;
                if (rx_n == 8) begin
                    rx_q.push_back(rx_sh);
                    rx_n = 0;
                end
            end
            acc = bus.PUSH && (sz < DEPTH);
            if (bus.PUSH && !acc) m_ovf = 1'b1;
            if (m_act && m_ph == 0) void'(q.pop_front());
            if (acc) q.push_back(bus.DIN);
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (m_act) begin
                if (m_ph < 9) begin
                    m_ph++;
                end else if (bus.S_EMPTY) begin
                    if (sz > 0) m_ph = 0;
                    else begin m_act = 1'b0; m_fin = 1'b1; end
                end
            end else if (bus.START) begin
                if (sz > 0) begin m_act = 1'b1; m_ph = 0; end
                else m_fin = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("busy",     32'(bus.BUSY),     32'(m_act || m_fin));
            chk("done",     32'(bus.DONE),     32'(m_fin));
            chk("s_write",  32'(bus.S_WRITE),  32'(m_act && m_ph == 0));
            chk("s_te",     32'(bus.S_TE),     32'(m_act && m_ph >= 1 && m_ph <= 8));
            chk("count",    32'(bus.COUNT),    32'(q.size()));
            chk("ready",    32'(bus.READY),    32'(q.size() < DEPTH));
            chk("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
            if (m_act && m_ph == 0) chk("s_data", 32'(bus.S_DATA), 32'(q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.DIN  = b;
        bus.PUSH = 1'b1;
        tick();
        bus.PUSH = 1'b0;
    endtask

    task automatic start_burst(output int k);
        bus.START = 1'b1;
        tick();
        k = cyc;
        bus.START = 1'b0;
    endtask

    // Latency is counted in cycles, with the LOAD cycle after START as 1.
    task automatic wait_done(input int k, input int exp_lat, input string name);
        int seen;
        seen = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) begin
                seen = cyc - k + 1;
                break;
            end
        end
        chk(name, 32'(seen), 32'(exp_lat));
    endtask

    task automatic check_rx(input string name, input logic [7:0] e[$]);
        chk({name, "_n"}, 32'(rx_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < rx_q.size()) chk(name, 32'(rx_q[i]), 32'(e[i]));
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        rx_q.delete();
    endtask

    initial begin
        int k;
        int dn;
        logic [7:0] e[$];
        bus.DIN   = 8'h00;
        bus.PUSH  = 1'b0;
        bus.START = 1'b0;

        do_reset();
        @(negedge clk);
        chk("rst_count",   32'(bus.COUNT),    32'd0);
        chk("rst_ready",   32'(bus.READY),    32'd1);
        chk("rst_ovf",     32'(bus.OVERFLOW), 32'd0);
        chk("rst_busy",    32'(bus.BUSY),     32'd0);
        chk("rst_done",    32'(bus.DONE),     32'd0);
        chk("rst_sdata",   32'(bus.S_DATA),   32'd0);
        chk("rst_swrite",  32'(bus.S_WRITE),  32'd0);
        chk("rst_ste",     32'(bus.S_TE),     32'd0);

        // Two-byte burst.
        push_byte(8'h43);
        push_byte(8'h5F);
        start_burst(k);
        @(negedge clk);
        chk("t1_load_count", 32'(bus.COUNT), 32'd2);
        wait_done(k, 21, "t1_done_lat");
        e = '{8'h43, 8'h5F};
        check_rx("t1_rx", e);

        // Overflow on the fifth push.
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        @(negedge clk);
        chk("t2_ready_full", 32'(bus.READY), 32'd0);
        chk("t2_count_full", 32'(bus.COUNT), 32'd4);
        push_byte(8'h55);
        @(negedge clk);
        chk("t2_ovf",      32'(bus.OVERFLOW), 32'd1);
        chk("t2_count_ov", 32'(bus.COUNT),    32'd4);
        start_burst(k);
        wait_done(k, 41, "t2_done_lat");
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_rx("t2_rx", e);
        chk("t2_ovf_sticky", 32'(bus.OVERFLOW), 32'd1);

        // Start with an empty queue.
        do_reset();
        start_burst(k);
        wait_done(k, 1, "t3_done_lat");
        chk("t3_rx_none", 32'(rx_q.size()), 32'd0);

        // Byte pushed mid-shift joins the burst.
        do_reset();
        push_byte(8'h3C);
        start_burst(k);
        repeat (3) tick();
        push_byte(8'hA5);
        wait_done(k, 21, "t4_done_lat");
        e = '{8'h3C, 8'hA5};
        check_rx("t4_rx", e);

        // Reset during the fourth shift cycle aborts the burst.
        do_reset();
        push_byte(8'h96);
        push_byte(8'h77);
        start_burst(k);
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("t5_ste",   32'(bus.S_TE),  32'd0);
        chk("t5_busy",  32'(bus.BUSY),  32'd0);
        chk("t5_count", 32'(bus.COUNT), 32'd0);
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) dn++;
        end
        chk("t5_no_done", 32'(dn), 32'd0);
        chk("t5_rx_none", 32'(rx_q.size()), 32'd0);

        // Sender slow to report empty: DRAIN stretches by 3 cycles.
        do_reset();
        push_byte(8'h81);
        push_byte(8'h42);
        start_burst(k);
        stall = 1'b1;
        repeat (11) tick();
        @(negedge clk);
        chk("t6_drain_busy", 32'(bus.BUSY),    32'd1);
        chk("t6_drain_te",   32'(bus.S_TE),    32'd0);
        chk("t6_drain_wr",   32'(bus.S_WRITE), 32'd0);
        tick();
        stall = 1'b0;
        wait_done(k, 24, "t6_done_lat");
        e = '{8'h81, 8'h42};
        check_rx("t6_rx", e);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_tx_feeder.md
# spi_tx_feeder

Byte-queue and transfer sequencer that sits directly upstream of the SPI `sender`. It buffers host bytes in a small FIFO and, on a start command, drives the sender's `DATA`/`WRITE`/`TE` inputs to shift each queued byte out on `MOSI` back-to-back. It pulses a completion flag when the queue is drained.

## Interface
Parameters:
- `WIDTH`, 8: byte width; equals the sender shift length.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- `CLK` in, 1: single clock, rising edge.
- `CLR` in, 1: reset, synchronous, active-high.
- `DIN` in, WIDTH: host byte to enqueue.
- `PUSH` in, 1: enqueue `DIN` at this edge.
- `START` in, 1: begin a burst; sampled only in IDLE.
- `READY` out, 1: FIFO not full.
- `COUNT` out, clog2(DEPTH)+1: FIFO occupancy.
- `OVERFLOW` out, 1: sticky; set when a push is dropped.
- `BUSY` out, 1: high in any state other than IDLE.
- `DONE` out, 1: one-cycle pulse at burst end.
- `S_DATA` out, WIDTH: to sender `DATA`; the FIFO head byte.
- `S_WRITE` out, 1: to sender `WRITE`.
- `S_TE` out, 1: to sender `TE`.
- `S_EMPTY` in, 1: from sender `EMPTY_STATE`.

## Operation
- Sender contract:
  - The sender loads `DATA` at an edge where `WRITE=1`.
  - It shifts one bit, MSB first, per edge while `TE=1`.
  - `EMPTY_STATE=1` once all 8 bits have left.
- FSM states: IDLE, LOAD, SHIFT, DRAIN, FINISH.
- IDLE:
  - `START=1` with `COUNT>0` moves to LOAD.
  - `START=1` with `COUNT=0` moves to FINISH; no sender activity occurs.
- LOAD (1 cycle):
  - `S_WRITE=1` and `S_DATA` = head byte.
  - Pop at the edge leaving the state; go to SHIFT.
  - The bit counter clears to 0.
- SHIFT:
  - `S_TE=1`; the bit counter increments each edge.
  - After 8 cycles (counter reaches WIDTH), go to DRAIN.
- DRAIN (1 cycle minimum, `S_TE=0`):
  - Wait for `S_EMPTY=1`.
  - Then go to LOAD if `COUNT>0`, else FINISH.
- FINISH (1 cycle): `DONE=1`, then go to IDLE.
- All outputs are Moore-decoded from registered state and FIFO.
- `S_WRITE` and `S_TE` are never high together.
- FIFO push:
  - Accepted whenever `COUNT<DEPTH`, in any state, including during a burst.
  - A byte pushed mid-burst joins the same burst if it arrives before the DRAIN decision.
- Push while full: the byte is discarded, `COUNT` is unchanged, and `OVERFLOW` goes to 1 until `CLR`.
- Simultaneous push and pop (edge leaving LOAD): both take effect and `COUNT` is unchanged. A push into a full FIFO on the pop edge is still rejected, because fullness is judged before the pop.
- Pointers wrap modulo DEPTH.
- `START` while `BUSY` is ignored, not queued.

## Timing
- Reset (`CLR=1` at an edge) takes effect at that edge:
  - State becomes IDLE.
  - FIFO is emptied and pointers are zeroed.
  - `COUNT=0`, `READY=1`, `OVERFLOW=0`, `BUSY=0`, `DONE=0`, `S_WRITE=0`, `S_TE=0`, `S_DATA=0`.
- `CLR` mid-burst aborts immediately: `S_TE` is low in the cycle after the edge, and no `DONE` pulse occurs.
- `CLR` has priority over `PUSH` and `START` in the same cycle.
- With `START` sampled at edge k and `S_EMPTY` returning by the DRAIN cycle:
  - LOAD during cycle k+1.
  - SHIFT during cycles k+2..k+9.
  - DRAIN during cycle k+10.
  - Next LOAD at k+11, or FINISH at k+11 with `DONE` high for that cycle.
- Steady state is 10 cycles per byte.
- Burst of N bytes: `BUSY` high for 10·N+1 cycles, starting at cycle k+1.
- `READY`/`COUNT` update one edge after `PUSH`.

## Structure
- Shared include `spi_defs.vh` holds:
  - FSM state encodings (3-bit).
  - `SPI_FRAME_BITS=8`.
  - The sender-contract constants, reused later by a receiver-side collector.
- Natural sub-module `byte_fifo` (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, head, count, full, empty.
  - Synchronous `CLR`; no read latency, since head is combinationally available.
- Top level: FSM, bit counter (clog2(WIDTH)+1 bits), overflow flag.
- Bench: instantiate the real `sender` and `receiver`, with `MISO` looped to `MOSI`, and check end to end.

## Test plan
- Reset, then push 0x43 and 0x5F, then `START` → `COUNT` goes 2→1→0; `MOSI` carries 01000011 then 01011111; `DONE` pulses once, 21 cycles after `START`.
- Push 5 bytes into DEPTH=4 → `READY=0` after the 4th; the 5th is dropped; `OVERFLOW=1` stays set; `COUNT=4`.
- `START` with an empty FIFO → `DONE` pulses in cycle k+1; `S_WRITE` and `S_TE` stay 0.
- Push during SHIFT of byte 1 (0xA5 queued) → that byte follows in the same burst, and `DONE` comes only after it.
- `CLR` asserted in the 4th SHIFT cycle → next cycle `S_TE=0`, `BUSY=0`, `COUNT=0`; no `DONE`.
- Hold `S_EMPTY=0` for 3 extra cycles → FSM stays in DRAIN with `S_TE=0`, then resumes LOAD once `S_EMPTY=1`.
